// File: rtl/process_data_mac_pipe.sv
// process_data_mac_pipe: pipelined multiply / multiply-accumulate with valid/ready
// handshake, per-operand signedness and a wrap-flagged running accumulator.
`timescale 1ns/1ps
module process_data_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 21,
    parameter int din1_WIDTH = 23,
    parameter int dout_WIDTH = 43,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int unused_id = ID;

    function automatic logic signed [dout_WIDTH-1:0] ext0(input logic [din0_WIDTH-1:0] d);
        if (SIGNED0 != 0) return dout_WIDTH'(signed'(d));
        return dout_WIDTH'(d);
    endfunction

    function automatic logic signed [dout_WIDTH-1:0] ext1(input logic [din1_WIDTH-1:0] d);
        if (SIGNED1 != 0) return dout_WIDTH'(signed'(d));
        return dout_WIDTH'(d);
    endfunction

    function automatic logic [dout_WIDTH-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
        logic signed [dout_WIDTH-1:0] ea;
        logic signed [dout_WIDTH-1:0] eb;
        ea = ext0(a);
        eb = ext1(b);
        return ea * eb;
    endfunction

    // Carry out in unsigned mode, two's-complement overflow otherwise.
    function automatic logic add_wrap(input logic [dout_WIDTH-1:0] a,
                                      input logic [dout_WIDTH-1:0] b,
                                      input logic [dout_WIDTH-1:0] s);
        logic [dout_WIDTH:0] full;
        if (SIGNED0 != 0 || SIGNED1 != 0)
            return (a[dout_WIDTH-1] == b[dout_WIDTH-1]) && (s[dout_WIDTH-1] != a[dout_WIDTH-1]);
        full = {1'b0, a} + {1'b0, b};
        return full[dout_WIDTH];
    endfunction

    logic                  advance;
    logic                  fin_vld;
    logic                  fin_en;
    logic                  fin_clr;
    logic [din0_WIDTH-1:0] fin_d0;
    logic [din1_WIDTH-1:0] fin_d1;
    logic [dout_WIDTH-1:0] acc;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stages 1..NUM_STAGE-1: raw operands and sideband travel with their valid bit
    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fin_vld = in_valid;
            assign fin_d0  = din0;
            assign fin_d1  = din1;
            assign fin_en  = acc_en;
            assign fin_clr = acc_clr;
        end else begin : g_pipe
            localparam int D = NUM_STAGE - 1;
            logic                  vld_p [D];
            logic [din0_WIDTH-1:0] d0_p  [D];
            logic [din1_WIDTH-1:0] d1_p  [D];
            logic                  en_p  [D];
            logic                  clr_p [D];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < D; i++) vld_p[i] <= 1'b0;
                end else if (advance) begin
                    vld_p[0] <= in_valid;
                    for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            always_ff @(posedge ap_clk) begin
                if (advance) begin
                    d0_p[0]  <= din0;
                    d1_p[0]  <= din1;
                    en_p[0]  <= acc_en;
                    clr_p[0] <= acc_clr;
                    for (int i = 1; i < D; i++) begin
                        d0_p[i]  <= d0_p[i-1];
                        d1_p[i]  <= d1_p[i-1];
                        en_p[i]  <= en_p[i-1];
                        clr_p[i] <= clr_p[i-1];
                    end
                end
            end

            assign fin_vld = vld_p[D-1];
            assign fin_d0  = d0_p[D-1];
            assign fin_d1  = d1_p[D-1];
            assign fin_en  = en_p[D-1];
            assign fin_clr = clr_p[D-1];
        end
    endgenerate

    logic                  use_acc;
    logic                  sum_ovf;
    logic [dout_WIDTH-1:0] prod;
    logic [dout_WIDTH-1:0] base;
    logic [dout_WIDTH-1:0] sum;

    always_comb begin
        use_acc = fin_en && !fin_clr;
        prod    = mul(fin_d0, fin_d1);
        base    = use_acc ? acc : '0;
        sum     = base + prod;
        sum_ovf = use_acc && add_wrap(acc, prod, sum);
    end

    // Final stage: output register and accumulator update together
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                dout <= sum;
                ovf  <= sum_ovf;
                if (fin_en) acc <= sum;
            end
        end
    end

endmodule

// File: tb/tb_process_data_mac_pipe.sv
// Scoreboard bench for process_data_mac_pipe: an unsigned and a signed instance
// share stimulus; a model queues expected results at acceptance.
`timescale 1ns/1ps
module tb_process_data_mac_pipe;

    localparam int W0 = 21;
    localparam int W1 = 23;
    localparam int WO = 43;
    localparam longint UMAX = (longint'(1) << WO) - 1;
    localparam longint SMAX = (longint'(1) << (WO - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (WO - 1));

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W0-1:0] din0 = '0;
    logic [W1-1:0] din1 = '0;
    logic          acc_en = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, in_ready_s;
    logic          out_valid, out_valid_s;
    logic          ovf, ovf_s;
    logic [WO-1:0] dout, dout_s;

    always #5 ap_clk = ~ap_clk;

    process_data_mac_pipe u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf)
    );

    process_data_mac_pipe #(.SIGNED0(1), .SIGNED1(1)) u_dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .ovf(ovf_s)
    );

    typedef struct packed {
        logic [WO-1:0] du;
        logic          ou;
        logic [WO-1:0] ds;
        logic          os;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [WO-1:0] macc_u = '0;
    logic [WO-1:0] macc_s = '0;
    int            checks = 0;
    int            failures = 0;
    logic          prod_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WO-1:0] mmul(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                           input bit sgn);
        longint sa, sbv, p;
        sa  = sgn ? longint'(signed'(a)) : longint'(a);
        sbv = sgn ? longint'(signed'(b)) : longint'(b);
        p   = sa * sbv;
        return p[WO-1:0];
    endfunction

    function automatic bit movf(input logic [WO-1:0] x, input logic [WO-1:0] y, input bit sgn);
        longint s;
        if (!sgn) begin
            s = longint'(x) + longint'(y);
            return s > UMAX;
        end
        s = longint'(signed'(x)) + longint'(signed'(y));
        return (s > SMAX) || (s < SMIN);
    endfunction

    task automatic model_push(input logic [W0-1:0] a, input logic [W1-1:0] b,
                              input logic en, input logic clr);
        exp_t e;
        logic [WO-1:0] pu, ps;
        pu = mmul(a, b, 1'b0);
        ps = mmul(a, b, 1'b1);
        if (en && !clr) begin
            e.du = macc_u + pu;
            e.ou = movf(macc_u, pu, 1'b0);
            e.ds = macc_s + ps;
            e.os = movf(macc_s, ps, 1'b1);
        end else begin
            e.du = pu;
            e.ou = 1'b0;
            e.ds = ps;
            e.os = 1'b0;
        end
        if (en) begin
            macc_u = e.du;
            macc_s = e.ds;
        end
        sb.push_back(e);
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                chk("valid_s", out_valid_s, 1'b1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("dout_u", dout, mon_e.du);
                    chk("ovf_u", ovf, mon_e.ou);
                    chk("dout_s", dout_s, mon_e.ds);
                    chk("ovf_s", ovf_s, mon_e.os);
                end
            end
            if (in_valid && in_ready) model_push(din0, din1, acc_en, acc_clr);
        end
    end

    task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b,
                        input logic en, input logic clr);
        logic ok;
        int   n;
        din0 = a; din1 = b; acc_en = en; acc_clr = clr; in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge ap_clk);
            ok = in_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("send_accept", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int   n;
        logic seen;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single beat: latency and in_ready
        send(21'd3, 23'd5, 1'b0, 1'b0);
        chk("t1_valid_n", out_valid, 1'b0);
        chk("t1_ready_n", in_ready, 1'b1);
        @(posedge ap_clk); #1;
        chk("t1_valid_n1", out_valid, 1'b0);
        @(posedge ap_clk); #1;
        chk("t1_valid_n2", out_valid, 1'b1);
        chk("t1_dout", dout, 43'd15);
        chk("t1_ovf", ovf, 1'b0);
        chk("t1_ready_n2", in_ready, 1'b1);
        drain();

        // Truncation and signed operands
        send(21'h1FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
        send(21'h1FFFFF, 23'd2, 1'b0, 1'b0);
        drain();

        // Accumulate chain, then wrap
        send(21'd10, 23'd10, 1'b1, 1'b1);
        send(21'd3, 23'd4, 1'b1, 1'b0);
        send(21'h1FFFFF, 23'h7FFFFF, 1'b1, 1'b1);
        send(21'h1FFFFF, 23'h7FFFFF, 1'b1, 1'b0);
        drain();

        // Backpressure: hold the first result for 5 cycles
        fork
            begin
                for (int k = 1; k <= 6; k++) send(W0'(k), 23'd1, 1'b0, 1'b0);
            end
            begin
                n = 0;
                seen = 1'b0;
                while (!seen && n < 50) begin
                    @(posedge ap_clk); #1;
                    seen = out_valid;
                    n++;
                end
                chk("t5_first_valid", seen, 1'b1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge ap_clk);
                    chk("t5_in_ready", in_ready, 1'b0);
                    chk("t5_dout_hold", dout, 43'd1);
                    chk("t5_valid_hold", out_valid, 1'b1);
                end
                @(posedge ap_clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random beats with random backpressure
        fork
            begin
                for (int k = 0; k < 40; k++)
                    send(W0'($urandom), W1'($urandom), 1'($urandom_range(0, 3) != 0),
                         1'($urandom_range(0, 4) == 0));
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge ap_clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight and acc=112
        send(21'd10, 23'd10, 1'b1, 1'b1);
        send(21'd3, 23'd4, 1'b1, 1'b0);
        drain();
        send(21'd1, 23'd1, 1'b0, 1'b0);
        send(21'd2, 23'd1, 1'b0, 1'b0);
        send(21'd3, 23'd1, 1'b0, 1'b0);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_dout", dout, '0);
        chk("t6_ovf", ovf, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_out_valid_s", out_valid_s, 1'b0);
        sb.delete();
        macc_u = '0;
        macc_s = '0;
        @(posedge ap_clk); #1;
        chk("t6_hold_valid", out_valid, 1'b0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        send(21'd2, 23'd2, 1'b1, 1'b0);
        drain();

        chk("final_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
